alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the datapath's 8-bit combinational ALU. It keeps that ALU's 5-bit opcode set and S/Z/Cy flag semantics, generalised to WIDTH bits. It adds registered outputs, a start/busy/done handshake, and iterative multi-bit shifts and rotates (one bit per cycle). The datapath sequencer issues one operation at a time and waits for `done` before reading `result` and `szcy`.

## Interface
- `WIDTH`, default 8: operand/result width; power of two, ≥4. Derived `SHAMT_W = $clog2(WIDTH)`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only when `busy`=0.
- `aluop` input 5: opcode, sampled with `start`.
- `a` input WIDTH: operand A, sampled with `start`.
- `b` input WIDTH: operand B / shift amount, sampled with `start`.
- `cy_in` input 1: carry in, sampled with `start`.
- `busy` output 1: iterative operation in progress.
- `done` output 1: one-cycle pulse; `result`/`szcy` updated this cycle.
- `result` output WIDTH: registered result, held until next `done`.
- `szcy` output 3: registered {S, Z, Cy}, held until next `done`.

## Operation
- States: IDLE, RUN. `busy` = (state==RUN).
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `szcy`=3'b000. Reset mid-RUN aborts; no `done` is produced.
- Accept: `start`=1 and state IDLE. `start` during RUN is ignored (not queued).
- Single-cycle opcodes are computed in WIDTH+1 bits, zero-extended. Bit WIDTH gives Cy:
  - 00000 → 0
  - 00001 → a
  - 00010 → b
  - 01000 → a+b
  - 01001 → a+b+1
  - 01010 → a+b+cy_in
  - 01011 → a−b
  - 01100 → a−b−1
  - 01101 → a−b−cy_in
  - 01110 → a+1
  - 01111 → a−1
  - 10000 → a&b
  - 10001 → a|b
  - 10010 → a^b
  - 10011 → ~a
  - 10100 → ~b
  - Subtract borrow appears as Cy=1 (bit WIDTH of the two's-complement extension).
  - For logic and move ops, bit WIDTH = 0.
- Iterative opcodes use k = `b[SHAMT_W-1:0]`:
  - 11000 SHR, logical.
  - 11001 ASR, MSB replicated.
  - 11010 ROR.
  - 11011 SHL.
  - 11100 ROL.
  - Each RUN cycle performs one 1-bit step and decrements the count.
  - Cy = last bit shifted or rotated out.
  - k=0: result=a, Cy=0, handled as single-cycle.
- Flags for all ops: S = result[WIDTH−1]; Z = (result==0); Cy as above.
- Undefined opcodes: result 0, szcy=3'b010, single-cycle.

## Timing
- Accept at edge T. Single-cycle op: `done`=1 and `result`/`szcy` valid in cycle T+1; `busy` stays 0.
- Shift/rotate with k≥1:
  - `busy`=1 in cycles T+1..T+k.
  - `done`=1 in cycle T+k+1, with `busy`=0.
  - Latency is k+1.
- `done` is high for exactly one cycle. A `start` in the `done` cycle is accepted (back-to-back issue).
- `result`/`szcy` change only on `done` cycles (or reset).
- No combinational path from inputs to outputs.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - Opcode 11101 = unsigned shift-add multiply, one partial product per cycle, WIDTH RUN cycles, latency WIDTH+1.
  - `result` = low WIDTH bits of a×b.
  - Cy = OR of the high WIDTH bits.
  - S and Z come from `result`.
- Not defined: 11101 is an undefined opcode (result 0, szcy=010, latency 1). No multiplier hardware is synthesised.

## Test plan
All scenarios use WIDTH=8.
- ADD a=0xFF, b=0x01 → `result`=0x00, `szcy`=011, `done` at T+1, `busy` never high.
- SUB-with-borrow 01101, a=0x00, b=0x00, cy_in=1 → `result`=0xFF, `szcy`=101. Undefined op 10111 → `result`=0x00, `szcy`=010.
- ASR a=0x80, b=7 → `busy` T+1..T+7, `done` at T+8, `result`=0xFF, `szcy`=100. A `start` pulsed at T+3 is ignored.
- ROR a=0x01, b=1 → `result`=0x80, `szcy`=101, `done` at T+2. Then SHL a=0x81, b=0 → `result`=0x81, `szcy`=100, `done` at T+1.
- SHL a=0x81, b=3 with `reset` asserted at T+2 → no `done`; `result`=0x00, `szcy`=000, `busy`=0 from T+3. A new ADD issued at T+3 completes at T+4.
- With `ALU_SEQ_MUL_EN`: MUL 0x10×0x10 → `done` at T+9, `result`=0x00, `szcy`=011. Without the macro: the same stimulus gives `done` at T+1 and `szcy`=010.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, iterative 1-bit-per-cycle shifts/rotates.
// Optional shift-add multiplier on opcode 11101 when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cy_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       szcy
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;

  localparam logic [4:0] OP_SHR = 5'b11000;
  localparam logic [4:0] OP_ASR = 5'b11001;
  localparam logic [4:0] OP_ROR = 5'b11010;
  localparam logic [4:0] OP_SHL = 5'b11011;
  localparam logic [4:0] OP_ROL = 5'b11100;
  localparam logic [4:0] OP_MUL = 5'b11101;

  typedef enum logic {IDLE, RUN} state_t;

  // Handshake: start is taken only in IDLE; done pulses one cycle when result/szcy load.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               done_d;
  logic [WIDTH-1:0]   result_d;
  logic [2:0]         szcy_d;
  logic [WIDTH:0]     alu_w;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   step_val;
  logic               step_cy;
  logic               iter_start;
  logic               mul_sel;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] hi_q, hi_d, mc_q, mc_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_lo;
  assign mul_sel = (aluop == OP_MUL);
  assign mul_sum = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mc_q} : '0);
  assign mul_lo  = {mul_sum[0], acc_q[WIDTH-1:1]};
`else
  assign mul_sel = 1'b0;
`endif

  function automatic logic [2:0] flags(input logic [WIDTH-1:0] r, input logic c);
    return {r[WIDTH-1], (r == '0), c};
  endfunction

  assign k          = b[SHAMT_W-1:0];
  assign busy       = (state_q == RUN);
  assign iter_start = (aluop >= OP_SHR) && (aluop <= OP_ROL) && (k != '0);

  always_comb begin
    alu_w = '0;
    case (aluop)
      5'b00001: alu_w = {1'b0, a};
      5'b00010: alu_w = {1'b0, b};
      5'b01000: alu_w = {1'b0, a} + {1'b0, b};
      5'b01001: alu_w = {1'b0, a} + {1'b0, b} + 1'b1;
      5'b01010: alu_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cy_in};
      5'b01011: alu_w = {1'b0, a} - {1'b0, b};
      5'b01100: alu_w = {1'b0, a} - {1'b0, b} - 1'b1;
      5'b01101: alu_w = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cy_in};
      5'b01110: alu_w = {1'b0, a} + 1'b1;
      5'b01111: alu_w = {1'b0, a} - 1'b1;
      5'b10000: alu_w = {1'b0, a & b};
      5'b10001: alu_w = {1'b0, a | b};
      5'b10010: alu_w = {1'b0, a ^ b};
      5'b10011: alu_w = {1'b0, ~a};
      5'b10100: alu_w = {1'b0, ~b};
      // zero shift amount degenerates to a move with Cy=0
      OP_SHR, OP_ASR, OP_ROR, OP_SHL, OP_ROL: alu_w = {1'b0, a};
      default:  alu_w = '0;
    endcase
  end

  always_comb begin
    step_val = acc_q;
    step_cy  = 1'b0;
    case (op_q)
      OP_SHR: begin step_val = {1'b0, acc_q[WIDTH-1:1]};            step_cy = acc_q[0];       end
      OP_ASR: begin step_val = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};  step_cy = acc_q[0];       end
      OP_ROR: begin step_val = {acc_q[0], acc_q[WIDTH-1:1]};        step_cy = acc_q[0];       end
      OP_SHL: begin step_val = {acc_q[WIDTH-2:0], 1'b0};            step_cy = acc_q[WIDTH-1]; end
      OP_ROL: begin step_val = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};  step_cy = acc_q[WIDTH-1]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    result_d = result;
    szcy_d   = szcy;
`ifdef ALU_SEQ_MUL_EN
    hi_d     = hi_q;
    mc_d     = mc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = aluop;
          if (iter_start) begin
            state_d = RUN;
            cnt_d   = {1'b0, k};
            acc_d   = a;
          end else if (mul_sel) begin
            state_d = RUN;
            cnt_d   = CNT_W'(WIDTH);
            acc_d   = b;
`ifdef ALU_SEQ_MUL_EN
            hi_d    = '0;
            mc_d    = a;
`endif
          end else begin
            done_d   = 1'b1;
            result_d = alu_w[WIDTH-1:0];
            szcy_d   = flags(alu_w[WIDTH-1:0], alu_w[WIDTH]);
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
          hi_d  = mul_sum[WIDTH:1];
          acc_d = mul_lo;
          if (cnt_q == CNT_W'(1)) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            result_d = mul_lo;
            szcy_d   = flags(mul_lo, |mul_sum[WIDTH:1]);
          end
        end else
`endif
        begin
          acc_d = step_val;
          if (cnt_q == CNT_W'(1)) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            result_d = step_val;
            szcy_d   = flags(step_val, step_cy);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      done    <= 1'b0;
      result  <= '0;
      szcy    <= 3'b000;
`ifdef ALU_SEQ_MUL_EN
      hi_q    <= '0;
      mc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      done    <= done_d;
      result  <= result_d;
      szcy    <= szcy_d;
`ifdef ALU_SEQ_MUL_EN
      hi_q    <= hi_d;
      mc_q    <= mc_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed scenarios plus a random mix,
// with expected {result, szcy} and latency queued at issue and popped on done.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   aluop;
  logic [W-1:0] a, b;
  logic         cy_in;
  logic         busy, done;
  logic [W-1:0] result;
  logic [2:0]   szcy;

  int total = 0;
  int bad   = 0;
  logic [W+2:0] exp_q[$];
  int           lat_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .aluop(aluop), .a(a), .b(b),
    .cy_in(cy_in), .busy(busy), .done(done), .result(result), .szcy(szcy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+2:0] model(input logic [4:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic ci);
    logic [W:0]     r;
    logic [2*W-1:0] p;
    int             k;
    k = int'(y[2:0]);
    r = '0;
    p = '0;
    case (op)
      5'b00001: r = {1'b0, x};
      5'b00010: r = {1'b0, y};
      5'b01000: r = 9'(x) + 9'(y);
      5'b01001: r = 9'(x) + 9'(y) + 9'd1;
      5'b01010: r = 9'(x) + 9'(y) + 9'(ci);
      5'b01011: r = 9'(x) - 9'(y);
      5'b01100: r = 9'(x) - 9'(y) - 9'd1;
      5'b01101: r = 9'(x) - 9'(y) - 9'(ci);
      5'b01110: r = 9'(x) + 9'd1;
      5'b01111: r = 9'(x) - 9'd1;
      5'b10000: r = {1'b0, x & y};
      5'b10001: r = {1'b0, x | y};
      5'b10010: r = {1'b0, x ^ y};
      5'b10011: r = {1'b0, ~x};
      5'b10100: r = {1'b0, ~y};
      5'b11000: begin r[W-1:0] = x >> k; r[W] = (k != 0) ? x[k-1] : 1'b0; end
      5'b11001: begin r[W-1:0] = W'($signed(x) >>> k); r[W] = (k != 0) ? x[k-1] : 1'b0; end
      5'b11010: begin r[W-1:0] = (x >> k) | (x << (W - k)); r[W] = (k != 0) ? r[W-1] : 1'b0; end
      5'b11011: begin r[W-1:0] = x << k; r[W] = (k != 0) ? x[W-k] : 1'b0; end
      5'b11100: begin r[W-1:0] = (x << k) | (x >> (W - k)); r[W] = (k != 0) ? r[0] : 1'b0; end
`ifdef ALU_SEQ_MUL_EN
      5'b11101: begin p = (2*W)'(x) * (2*W)'(y); r[W-1:0] = p[W-1:0]; r[W] = |p[2*W-1:W]; end
`endif
      default: r = '0;
    endcase
    return {r[W-1:0], r[W-1], (r[W-1:0] == '0), r[W]};
  endfunction

  function automatic int latency(input logic [4:0] op, input logic [W-1:0] y);
    int k;
    k = int'(y[2:0]);
    if (op >= 5'b11000 && op <= 5'b11100 && k != 0) return k + 1;
`ifdef ALU_SEQ_MUL_EN
    if (op == 5'b11101) return W + 1;
`endif
    return 1;
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic drive(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci);
    aluop = op; a = x; b = y; cy_in = ci; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci);
    exp_q.push_back(model(op, x, y, ci));
    lat_q.push_back(latency(op, y));
    drive(op, x, y, ci);
  endtask

  // Samples each cycle at negedge; optionally pulses a stray start in cycle T+pulse_at.
  task automatic wait_done(input int pulse_at);
    logic [W+2:0] e;
    int           l;
    bit           seen;
    e    = exp_q.pop_front();
    l    = lat_q.pop_front();
    seen = 1'b0;
    for (int n = 1; n <= l + 2 && !seen; n++) begin
      @(negedge clk);
      if (pulse_at != 0 && n == pulse_at) begin
        start = 1'b1; aluop = 5'b01000; a = 8'h55; b = 8'h11;
      end
      if (pulse_at != 0 && n == pulse_at + 1) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        check("latency", 16'(n), 16'(l));
        check("result", 16'(result), 16'(e[W+2:3]));
        check("szcy", 16'(szcy), 16'(e[2:0]));
        check("busy_at_done", 16'(busy), 16'(0));
      end else begin
        check("busy", 16'(busy), 16'(n < l));
      end
    end
    if (!seen) check("done_timeout", 16'(0), 16'(1));
    @(negedge clk);
    check("done_pulse", 16'(done), 16'(0));
    check("hold", 16'({result, szcy}), 16'(e));
  endtask

  logic [4:0] ops [24] = '{5'b00000, 5'b00001, 5'b00010, 5'b01000, 5'b01001, 5'b01010,
                           5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000,
                           5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b11000, 5'b11001,
                           5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b10111, 5'b11110};

  initial begin
    reset = 1'b1; start = 1'b0; aluop = '0; a = '0; b = '0; cy_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 16'(busy), 16'(0));
    check("reset_done", 16'(done), 16'(0));
    check("reset_result", 16'(result), 16'(0));
    check("reset_szcy", 16'(szcy), 16'(0));
    reset = 1'b0;
    @(negedge clk);

    issue(5'b01000, 8'hFF, 8'h01, 1'b0); wait_done(0);
    issue(5'b01101, 8'h00, 8'h00, 1'b1); wait_done(0);
    issue(5'b10111, 8'h5A, 8'hA5, 1'b0); wait_done(0);
    issue(5'b11001, 8'h80, 8'h07, 1'b0); wait_done(3);
    repeat (3) begin
      @(negedge clk);
      check("stray_start_done", 16'(done), 16'(0));
      check("stray_start_busy", 16'(busy), 16'(0));
    end
    issue(5'b11010, 8'h01, 8'h01, 1'b0); wait_done(0);
    issue(5'b11011, 8'h81, 8'h00, 1'b0); wait_done(0);

    // Reset in the middle of a shift aborts it without a done.
    drive(5'b11011, 8'h81, 8'h03, 1'b0);
    @(negedge clk);
    check("abort_busy_t1", 16'(busy), 16'(1));
    check("abort_done_t1", 16'(done), 16'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 16'(busy), 16'(0));
    check("abort_done", 16'(done), 16'(0));
    check("abort_result", 16'(result), 16'(0));
    check("abort_szcy", 16'(szcy), 16'(0));
    issue(5'b01000, 8'h12, 8'h34, 1'b0); wait_done(0);

    issue(5'b11101, 8'h10, 8'h10, 1'b0); wait_done(0);

    for (int i = 0; i < 30; i++) begin
      issue(ops[$urandom_range(0, 23)], 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait_done(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
